// File: rtl/axis_operand_issuer_if.sv
// rtl/axis_operand_issuer_if.sv - operand a/b AXI-stream channel bundle
// master drives tvalid/tdata on both channels; slave returns the per-channel tready.
interface axis_operand_issuer_if #(
  parameter int WIDTH = 32
);
  logic             m_axis_a_tvalid;
  logic             m_axis_a_tready;
  logic [WIDTH-1:0] m_axis_a_tdata;
  logic             m_axis_b_tvalid;
  logic             m_axis_b_tready;
  logic [WIDTH-1:0] m_axis_b_tdata;

  modport master (
    output m_axis_a_tvalid, m_axis_a_tdata, m_axis_b_tvalid, m_axis_b_tdata,
    input  m_axis_a_tready, m_axis_b_tready
  );

  modport slave (
    input  m_axis_a_tvalid, m_axis_a_tdata, m_axis_b_tvalid, m_axis_b_tdata,
    output m_axis_a_tready, m_axis_b_tready
  );
endinterface

// File: rtl/axis_operand_issuer.sv
// rtl/axis_operand_issuer.sv - operand-pair FIFO feeding independent a/b AXI-stream channels
// Optional AXIS_ISSUE_COUNT_EN adds issued_count_out, a wrapping count of retired pairs.
module axis_operand_issuer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk_in,
  input  logic                     rst_in_n,
  input  logic                     push_in,
  input  logic [WIDTH-1:0]         a_in,
  input  logic [WIDTH-1:0]         b_in,
  input  logic                     flush_in,
  output logic                     full_out,
  output logic                     empty_out,
  output logic [$clog2(DEPTH):0]   level_out,
  output logic                     drop_out,
  axis_operand_issuer_if.master    m_axis
`ifdef AXIS_ISSUE_COUNT_EN
  ,
  output logic [31:0]              issued_count_out
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_A_SENT = 2'd1,
    ST_B_SENT = 2'd2
  } pair_state_t;

  logic [WIDTH-1:0] r_mem_a [DEPTH];
  logic [WIDTH-1:0] r_mem_b [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             r_drop;
  pair_state_t      r_state;
  pair_state_t      w_state_nxt;

  logic w_empty;
  logic w_full;
  logic w_push_ok;
  logic w_a_tvalid;
  logic w_b_tvalid;
  logic w_hs_a;
  logic w_hs_b;
  logic w_retire;

  assign w_empty   = (r_level == '0);
  assign w_full    = (r_level == LW'(DEPTH));
  // Fullness uses the pre-edge level, so a push while full is dropped even if the head retires.
  assign w_push_ok = push_in && !w_full;

  always_comb begin
    w_state_nxt = r_state;
    w_a_tvalid  = 1'b0;
    w_b_tvalid  = 1'b0;
    if (!w_empty) begin
      w_a_tvalid = (r_state != ST_A_SENT);
      w_b_tvalid = (r_state != ST_B_SENT);
    end
    w_hs_a   = w_a_tvalid && m_axis.m_axis_a_tready;
    w_hs_b   = w_b_tvalid && m_axis.m_axis_b_tready;
    w_retire = ((r_state == ST_A_SENT) || w_hs_a) && ((r_state == ST_B_SENT) || w_hs_b);
    if (flush_in || w_retire) begin
      w_state_nxt = ST_IDLE;
    end else if (w_hs_a) begin
      w_state_nxt = ST_A_SENT;
    end else if (w_hs_b) begin
      w_state_nxt = ST_B_SENT;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_drop   <= 1'b0;
    end else if (flush_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_drop   <= 1'b0;
    end else begin
      r_drop <= push_in && w_full;
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_retire) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push_ok, w_retire})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Payload storage carries no reset; the level counter alone says which entries are live.
  always_ff @(posedge clk_in) begin
    if (w_push_ok) begin
      r_mem_a[r_wr_ptr] <= a_in;
      r_mem_b[r_wr_ptr] <= b_in;
    end
  end

`ifdef AXIS_ISSUE_COUNT_EN
  logic [31:0] r_issued_count;

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      r_issued_count <= '0;
    end else if (flush_in) begin
      r_issued_count <= '0;
    end else if (w_retire) begin
      r_issued_count <= r_issued_count + 32'd1;
    end
  end

  assign issued_count_out = r_issued_count;
`endif

  assign m_axis.m_axis_a_tvalid = w_a_tvalid;
  assign m_axis.m_axis_b_tvalid = w_b_tvalid;
  assign m_axis.m_axis_a_tdata  = r_mem_a[r_rd_ptr];
  assign m_axis.m_axis_b_tdata  = r_mem_b[r_rd_ptr];

  assign full_out  = w_full;
  assign empty_out = w_empty;
  assign level_out = r_level;
  assign drop_out  = r_drop;

endmodule

// File: tb/tb_axis_operand_issuer.sv
// tb/tb_axis_operand_issuer.sv - directed self-checking bench for axis_operand_issuer
// Optional AXIS_ISSUE_COUNT_EN also checks issued_count_out.
module tb_axis_operand_issuer;

  logic        clk_in;
  logic        rst_in_n;
  logic        push_in;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        flush_in;
  logic        full_out;
  logic        empty_out;
  logic [3:0]  level_out;
  logic        drop_out;
`ifdef AXIS_ISSUE_COUNT_EN
  logic [31:0] issued_count_out;
`endif

  int n_total;
  int n_bad;

  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic        mon_en;

  axis_operand_issuer_if #(.WIDTH(32)) axis_if ();

  axis_operand_issuer #(.WIDTH(32), .DEPTH(8)) dut (
    .clk_in    (clk_in),
    .rst_in_n  (rst_in_n),
    .push_in   (push_in),
    .a_in      (a_in),
    .b_in      (b_in),
    .flush_in  (flush_in),
    .full_out  (full_out),
    .empty_out (empty_out),
    .level_out (level_out),
    .drop_out  (drop_out),
    .m_axis    (axis_if)
`ifdef AXIS_ISSUE_COUNT_EN
    ,
    .issued_count_out (issued_count_out)
`endif
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Handshakes are recorded half a cycle before the edge that completes them.
  always @(negedge clk_in) begin
    if (mon_en) begin
      if (axis_if.m_axis_a_tvalid && axis_if.m_axis_a_tready) qa.push_back(axis_if.m_axis_a_tdata);
      if (axis_if.m_axis_b_tvalid && axis_if.m_axis_b_tready) qb.push_back(axis_if.m_axis_b_tdata);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int np;
    int cyc;
    n_total = 0;
    n_bad   = 0;
    mon_en  = 1'b0;
    push_in = 1'b0;
    flush_in = 1'b0;
    a_in = '0;
    b_in = '0;
    axis_if.m_axis_a_tready = 1'b0;
    axis_if.m_axis_b_tready = 1'b0;
    rst_in_n = 1'b1;
    #2 rst_in_n = 1'b0;
    repeat (2) tick();

    chk("rst_a_tvalid", axis_if.m_axis_a_tvalid, 0);
    chk("rst_b_tvalid", axis_if.m_axis_b_tvalid, 0);
    chk("rst_full", full_out, 0);
    chk("rst_empty", empty_out, 1);
    chk("rst_level", level_out, 0);
    chk("rst_drop", drop_out, 0);
    rst_in_n = 1'b1;
    tick();

    // single pair, both channels ready
    axis_if.m_axis_a_tready = 1'b1;
    axis_if.m_axis_b_tready = 1'b1;
    push_in = 1'b1; a_in = 32'h3F80_0000; b_in = 32'h4000_0000;
    tick();
    push_in = 1'b0;
    chk("t1_a_tvalid", axis_if.m_axis_a_tvalid, 1);
    chk("t1_b_tvalid", axis_if.m_axis_b_tvalid, 1);
    chk("t1_a_tdata", axis_if.m_axis_a_tdata, 32'h3F80_0000);
    chk("t1_b_tdata", axis_if.m_axis_b_tdata, 32'h4000_0000);
    tick();
    chk("t1_empty", empty_out, 1);
    chk("t1_a_tvalid_off", axis_if.m_axis_a_tvalid, 0);

    // b backpressure while a completes
    axis_if.m_axis_a_tready = 1'b0;
    axis_if.m_axis_b_tready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      push_in = 1'b1; a_in = 32'h1000_0000 + i; b_in = 32'h2000_0000 + i;
      tick();
    end
    push_in = 1'b0;
    chk("t2_level3", level_out, 3);
    axis_if.m_axis_a_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_a_tvalid_held", axis_if.m_axis_a_tvalid, 0);
      chk("t2_b_tvalid_held", axis_if.m_axis_b_tvalid, 1);
      chk("t2_b_tdata_stable", axis_if.m_axis_b_tdata, 32'h2000_0001);
    end
    axis_if.m_axis_a_tready = 1'b0;
    axis_if.m_axis_b_tready = 1'b1;
    tick();
    chk("t2_a_tvalid_back", axis_if.m_axis_a_tvalid, 1);
    chk("t2_a_tdata_p2", axis_if.m_axis_a_tdata, 32'h1000_0002);
    chk("t2_level2", level_out, 2);
    axis_if.m_axis_a_tready = 1'b1;
    repeat (2) tick();
    chk("t2_empty", empty_out, 1);

    // overfill by one with both channels stalled
    axis_if.m_axis_a_tready = 1'b0;
    axis_if.m_axis_b_tready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      push_in = 1'b1; a_in = 32'hC000_0000 + i; b_in = 32'hD000_0000 + i;
      tick();
      if (i == 7) begin
        chk("t3_full", full_out, 1);
        chk("t3_level8", level_out, 8);
        chk("t3_no_drop_yet", drop_out, 0);
      end
    end
    push_in = 1'b0;
    chk("t3_drop_pulse", drop_out, 1);
    chk("t3_level_still8", level_out, 8);
    tick();
    chk("t3_drop_clear", drop_out, 0);
    axis_if.m_axis_a_tready = 1'b1;
    axis_if.m_axis_b_tready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("t3_a_tdata", axis_if.m_axis_a_tdata, 32'hC000_0000 + k);
      chk("t3_b_tdata", axis_if.m_axis_b_tdata, 32'hD000_0000 + k);
      tick();
    end
    chk("t3_empty", empty_out, 1);
    chk("t3_no_ninth", axis_if.m_axis_a_tvalid, 0);

    // push while full and head retiring in the same cycle
    axis_if.m_axis_a_tready = 1'b0;
    axis_if.m_axis_b_tready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      push_in = 1'b1; a_in = 32'hE000_0000 + i; b_in = 32'hF000_0000 + i;
      tick();
    end
    chk("t4_full", full_out, 1);
    axis_if.m_axis_a_tready = 1'b1;
    axis_if.m_axis_b_tready = 1'b1;
    a_in = 32'h1234_5678; b_in = 32'h8765_4321;
    tick();
    push_in = 1'b0;
    chk("t4_drop", drop_out, 1);
    chk("t4_level7", level_out, 7);
    chk("t4_head", axis_if.m_axis_a_tdata, 32'hE000_0001);
    repeat (7) tick();
    chk("t4_empty", empty_out, 1);

    // flush discards queued pairs
    axis_if.m_axis_a_tready = 1'b0;
    axis_if.m_axis_b_tready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      push_in = 1'b1; a_in = 32'h9000_0000 + i; b_in = 32'h9100_0000 + i;
      tick();
    end
    push_in = 1'b0;
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    chk("t5_flush_empty", empty_out, 1);
    chk("t5_flush_level", level_out, 0);
    chk("t5_flush_tvalid", axis_if.m_axis_a_tvalid, 0);
`ifdef AXIS_ISSUE_COUNT_EN
    chk("t5_flush_count", issued_count_out, 0);
`endif

    // 20 pairs under independent random readiness
    mon_en = 1'b1;
    np = 0;
    for (cyc = 0; cyc < 600; cyc++) begin
      if (np == 20 && empty_out) break;
      if (np < 20 && level_out < 8) begin
        push_in = 1'b1; a_in = 32'hA000_0000 + np; b_in = 32'hB000_0000 + np;
        np++;
      end else begin
        push_in = 1'b0;
      end
      axis_if.m_axis_a_tready = 1'($urandom_range(0, 1));
      axis_if.m_axis_b_tready = 1'($urandom_range(0, 1));
      tick();
    end
    push_in = 1'b0;
    mon_en = 1'b0;
    axis_if.m_axis_a_tready = 1'b0;
    axis_if.m_axis_b_tready = 1'b0;
    chk("t5_drained", (np == 20 && empty_out), 1);
    chk("t5_a_count", qa.size(), 20);
    chk("t5_b_count", qb.size(), 20);
    for (int i = 0; i < 20 && i < qa.size(); i++) chk("t5_a_order", qa[i], 32'hA000_0000 + i);
    for (int i = 0; i < 20 && i < qb.size(); i++) chk("t5_b_order", qb[i], 32'hB000_0000 + i);
`ifdef AXIS_ISSUE_COUNT_EN
    chk("t5_issued", issued_count_out, 20);
`endif

    // async reset while a has already handshaken
    for (int i = 0; i < 3; i++) begin
      push_in = 1'b1; a_in = 32'h5500_0000 + i; b_in = 32'h6600_0000 + i;
      tick();
    end
    push_in = 1'b0;
    axis_if.m_axis_a_tready = 1'b1;
    tick();
    axis_if.m_axis_a_tready = 1'b0;
    chk("t6_a_done", axis_if.m_axis_a_tvalid, 0);
    chk("t6_b_pending", axis_if.m_axis_b_tvalid, 1);
    chk("t6_level3", level_out, 3);
    #2 rst_in_n = 1'b0;
    #1;
    chk("t6_rst_a_tvalid", axis_if.m_axis_a_tvalid, 0);
    chk("t6_rst_b_tvalid", axis_if.m_axis_b_tvalid, 0);
    chk("t6_rst_level", level_out, 0);
    chk("t6_rst_empty", empty_out, 1);
    tick();
    rst_in_n = 1'b1;
    push_in = 1'b1; a_in = 32'h7700_0000; b_in = 32'h8800_0000;
    tick();
    push_in = 1'b0;
    chk("t6_new_a_tvalid", axis_if.m_axis_a_tvalid, 1);
    chk("t6_new_b_tvalid", axis_if.m_axis_b_tvalid, 1);
    chk("t6_new_a_tdata", axis_if.m_axis_a_tdata, 32'h7700_0000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
